// File: rtl/qm_pkg.sv
// Shared decode constants: opcodes, immediate formats and the link register index.
package qm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BR_LO = 6'h04;
  localparam logic [5:0] OP_BR_HI = 6'h07;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ST_LO = 6'h28;
  localparam logic [5:0] OP_ST_HI = 6'h2B;

  localparam int unsigned REG_RA = 31;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_mode_e;

  function automatic imm_mode_e imm_mode(input logic [5:0] op);
    imm_mode_e mode;
    mode = IMM_SEXT;
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) mode = IMM_ZEXT;
    else if (op == OP_LUI) mode = IMM_LUI;
    return mode;
  endfunction

  function automatic logic no_dest(input logic [5:0] op);
    return (op >= OP_BR_LO && op <= OP_BR_HI) || (op >= OP_ST_LO && op <= OP_ST_HI);
  endfunction

endpackage

// File: rtl/qm_regfile_p.sv
// 2-read/1-write register file; r0 reads as zero and is never written. No reset on storage.
module qm_regfile_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [RA_W-1:0]   ra_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  logic [RA_W-1:0]   ra_b_i,
  output logic [DATA_W-1:0] rd_b_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (we_i && wa_i != '0) mem_q[wa_i] <= wd_i;
  end

  assign rd_a_o = (ra_a_i == '0) ? '0 : mem_q[ra_a_i];
  assign rd_b_o = (ra_b_i == '0) ? '0 : mem_q[ra_b_i];

endmodule

// File: rtl/qm_decode_pipe.sv
// Registered decode stage: regfile read with optional bypass, immediate/destination decode,
// load-use interlock and a valid/ready output register with stall, flush and held-operand refresh.
module qm_decode_pipe
  import qm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter bit          BYPASS = 1'b1,
  parameter bit          HAZARD = 1'b1,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              di_valid,
  output logic              di_ready,
  input  logic [31:0]       di_IR,
  input  logic [31:0]       di_PC,
  output logic              do_valid,
  input  logic              do_ready,
  output logic [31:0]       do_IR,
  output logic [31:0]       do_PC,
  output logic [DATA_W-1:0] do_A,
  output logic [DATA_W-1:0] do_B,
  output logic [DATA_W-1:0] do_Imm,
  output logic [RA_W-1:0]   do_rd,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_rt,
  input  logic              flush
);

  logic [5:0]        op;
  logic [4:0]        rs_f, rt_f, rd_f, hrs_f, hrt_f;
  logic [RA_W-1:0]   rs, rt, rdr, hrs, hrt, dest;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rf_a, rf_b, opa, opb, imm;
  logic              hazard, accept, held, wb_hit;

  logic              valid_q, valid_d;
  logic [31:0]       ir_q, ir_d, pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [RA_W-1:0]   rd_q, rd_d;

  assign op    = di_IR[31:26];
  assign rs_f  = di_IR[25:21];
  assign rt_f  = di_IR[20:16];
  assign rd_f  = di_IR[15:11];
  assign imm16 = di_IR[15:0];
  assign rs    = rs_f[RA_W-1:0];
  assign rt    = rt_f[RA_W-1:0];
  assign rdr   = rd_f[RA_W-1:0];
  // Source indices of the instruction sitting in the output register.
  assign hrs_f = ir_q[25:21];
  assign hrt_f = ir_q[20:16];
  assign hrs   = hrs_f[RA_W-1:0];
  assign hrt   = hrt_f[RA_W-1:0];

  qm_regfile_p #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk_i  (sys_clk),
    .we_i   (wb_we),
    .wa_i   (wb_wa),
    .wd_i   (wb_wd),
    .ra_a_i (rs),
    .rd_a_o (rf_a),
    .ra_b_i (rt),
    .rd_b_o (rf_b)
  );

  assign wb_hit = wb_we && (wb_wa != '0);
  assign opa = (BYPASS && wb_hit && wb_wa == rs) ? wb_wd : rf_a;
  assign opb = (BYPASS && wb_hit && wb_wa == rt) ? wb_wd : rf_b;

  always_comb begin
    imm = DATA_W'($signed(imm16));
    unique case (imm_mode(op))
      IMM_ZEXT: imm = DATA_W'(imm16);
      IMM_LUI:  imm = DATA_W'({imm16, 16'h0000});
      default:  imm = DATA_W'($signed(imm16));
    endcase
  end

  always_comb begin
    dest = rt;
    if (op == OP_RTYPE)  dest = rdr;
    else if (op == OP_JAL) dest = RA_W'(REG_RA);
    else if (no_dest(op)) dest = '0;
  end

  assign hazard   = HAZARD && di_valid && ex_load && (ex_rt != '0) &&
                    (ex_rt == rs || ex_rt == rt);
  assign di_ready = sys_rst_n && !flush && !hazard && (!valid_q || do_ready);
  assign accept   = di_valid && di_ready;
  assign held     = valid_q && !do_ready;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ir_d    = di_IR;
      pc_d    = di_PC;
      a_d     = opa;
      b_d     = opb;
      imm_d   = imm;
      rd_d    = dest;
    end else if (do_ready) begin
      valid_d = 1'b0;
    end else if (held) begin
      // Keep stalled operands coherent with writeback regardless of BYPASS.
      if (wb_hit && wb_wa == hrs) a_d = wb_wd;
      if (wb_hit && wb_wa == hrt) b_d = wb_wd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
    end
  end

  assign do_valid = valid_q;
  assign do_IR    = ir_q;
  assign do_PC    = pc_q;
  assign do_A     = a_q;
  assign do_B     = b_q;
  assign do_Imm   = imm_q;
  assign do_rd    = rd_q;

endmodule

// File: tb/tb_qm_decode_pipe.sv
// Directed bench for qm_decode_pipe; two instances share stimulus, one with BYPASS=1, one with 0.
module tb_qm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        di_valid, do_ready, wb_we, ex_load, flush;
  logic [31:0] di_IR, di_PC, wb_wd;
  logic [4:0]  wb_wa, ex_rt;

  logic        di_ready1, do_valid1, di_ready0, do_valid0;
  logic [31:0] do_IR1, do_PC1, do_A1, do_B1, do_Imm1;
  logic [31:0] do_IR0, do_PC0, do_A0, do_B0, do_Imm0;
  logic [4:0]  do_rd1, do_rd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qm_decode_pipe #(.DATA_W(32), .NREGS(32), .BYPASS(1'b1), .HAZARD(1'b1)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .di_valid(di_valid), .di_ready(di_ready1),
    .di_IR(di_IR), .di_PC(di_PC), .do_valid(do_valid1), .do_ready(do_ready),
    .do_IR(do_IR1), .do_PC(do_PC1), .do_A(do_A1), .do_B(do_B1), .do_Imm(do_Imm1),
    .do_rd(do_rd1), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ex_load(ex_load),
    .ex_rt(ex_rt), .flush(flush)
  );

  qm_decode_pipe #(.DATA_W(32), .NREGS(32), .BYPASS(1'b0), .HAZARD(1'b1)) u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .di_valid(di_valid), .di_ready(di_ready0),
    .di_IR(di_IR), .di_PC(di_PC), .do_valid(do_valid0), .do_ready(do_ready),
    .do_IR(do_IR0), .do_PC(do_PC0), .do_A(do_A0), .do_B(do_B0), .do_Imm(do_Imm0),
    .do_rd(do_rd0), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ex_load(ex_load),
    .ex_rt(ex_rt), .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; di_valid = 1'b1; di_IR = 32'h24A6FFFF; di_PC = 32'h0;
    do_ready = 1'b1; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    ex_load = 1'b0; ex_rt = '0; flush = 1'b0;
    tick(); tick();
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL reset_di_ready got %b want 0", di_ready1); end
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL reset_do_valid got %b want 0", do_valid1); end
    checks++; if (do_IR1 !== 32'h0) begin errors++; $display("FAIL reset_do_IR got %h want 0", do_IR1); end
    checks++; if (do_A1 !== 32'h0) begin errors++; $display("FAIL reset_do_A got %h want 0", do_A1); end
    checks++; if (do_rd1 !== 5'd0) begin errors++; $display("FAIL reset_do_rd got %0d want 0", do_rd1); end
    rst_n = 1'b1; di_valid = 1'b0;
  endtask

  task automatic test_addiu();
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h1234;
    tick();
    wb_we = 1'b0;
    di_valid = 1'b1; di_IR = 32'h24A6FFFF; di_PC = 32'h100;
    #1;
    checks++; if (di_ready1 !== 1'b1) begin errors++; $display("FAIL addiu_ready got %b want 1", di_ready1); end
    tick();
    checks++; if (do_valid1 !== 1'b1) begin errors++; $display("FAIL addiu_valid got %b want 1", do_valid1); end
    checks++; if (do_A1 !== 32'h1234) begin errors++; $display("FAIL addiu_A got %h want 1234", do_A1); end
    checks++; if (do_Imm1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addiu_imm got %h want ffffffff", do_Imm1); end
    checks++; if (do_rd1 !== 5'd6) begin errors++; $display("FAIL addiu_rd got %0d want 6", do_rd1); end
    checks++; if (do_PC1 !== 32'h100) begin errors++; $display("FAIL addiu_pc got %h want 100", do_PC1); end
  endtask

  task automatic test_back_to_back();
    di_IR = 32'h34A68000; di_PC = 32'h104; tick();
    checks++; if (do_valid1 !== 1'b1) begin errors++; $display("FAIL ori_valid got %b want 1", do_valid1); end
    checks++; if (do_Imm1 !== 32'h00008000) begin errors++; $display("FAIL ori_imm got %h want 00008000", do_Imm1); end
    di_IR = 32'h3C068000; di_PC = 32'h108; tick();
    checks++; if (do_Imm1 !== 32'h80000000) begin errors++; $display("FAIL lui_imm got %h want 80000000", do_Imm1); end
    checks++; if (do_A1 !== 32'h0) begin errors++; $display("FAIL lui_A_r0 got %h want 0", do_A1); end
    checks++; if (do_IR1 !== 32'h3C068000) begin errors++; $display("FAIL lui_ir got %h want 3c068000", do_IR1); end
    di_IR = 32'h0C000010; tick();
    checks++; if (do_rd1 !== 5'd31) begin errors++; $display("FAIL jal_rd got %0d want 31", do_rd1); end
    checks++; if (do_Imm1 !== 32'h10) begin errors++; $display("FAIL jal_imm got %h want 10", do_Imm1); end
    di_IR = 32'hACA60004; tick();
    checks++; if (do_rd1 !== 5'd0) begin errors++; $display("FAIL sw_rd got %0d want 0", do_rd1); end
    di_IR = 32'h10A6FFFE; tick();
    checks++; if (do_rd1 !== 5'd0) begin errors++; $display("FAIL beq_rd got %0d want 0", do_rd1); end
    checks++; if (do_Imm1 !== 32'hFFFFFFFE) begin errors++; $display("FAIL beq_imm got %h want fffffffe", do_Imm1); end
    di_valid = 1'b0; tick();
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", do_valid1); end
  endtask

  task automatic test_bypass();
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hDEAD;
    di_valid = 1'b1; di_IR = 32'h00A53821; di_PC = 32'h180;
    tick();
    wb_we = 1'b0; di_valid = 1'b0;
    checks++; if (do_A1 !== 32'hDEAD) begin errors++; $display("FAIL byp1_A got %h want dead", do_A1); end
    checks++; if (do_B1 !== 32'hDEAD) begin errors++; $display("FAIL byp1_B got %h want dead", do_B1); end
    checks++; if (do_rd1 !== 5'd7) begin errors++; $display("FAIL addu_rd got %0d want 7", do_rd1); end
    checks++; if (do_A0 !== 32'h1234) begin errors++; $display("FAIL byp0_A got %h want 1234", do_A0); end
    checks++; if (do_B0 !== 32'h1234) begin errors++; $display("FAIL byp0_B got %h want 1234", do_B0); end
    tick();
  endtask

  task automatic test_hazard();
    ex_load = 1'b1; ex_rt = 5'd5;
    di_valid = 1'b1; di_IR = 32'h24A6FFFF; di_PC = 32'h200;
    #1;
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL haz_ready got %b want 0", di_ready1); end
    tick();
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL haz_bubble1 got %b want 0", do_valid1); end
    tick();
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL haz_bubble2 got %b want 0", do_valid1); end
    ex_rt = 5'd9;
    #1;
    checks++; if (di_ready1 !== 1'b1) begin errors++; $display("FAIL haz_nomatch_ready got %b want 1", di_ready1); end
    ex_rt = 5'd6;
    #1;
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL haz_rt_ready got %b want 0", di_ready1); end
    ex_load = 1'b0;
    #1;
    checks++; if (di_ready1 !== 1'b1) begin errors++; $display("FAIL haz_release_ready got %b want 1", di_ready1); end
    tick();
    di_valid = 1'b0;
    checks++; if (do_valid1 !== 1'b1) begin errors++; $display("FAIL haz_accept_valid got %b want 1", do_valid1); end
    checks++; if (do_A1 !== 32'hDEAD) begin errors++; $display("FAIL haz_accept_A got %h want dead", do_A1); end
  endtask

  task automatic test_hold_refresh();
    do_ready = 1'b0; wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h42;
    #1;
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL hold_ready got %b want 0", di_ready1); end
    tick();
    wb_we = 1'b0;
    checks++; if (do_valid1 !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", do_valid1); end
    checks++; if (do_A1 !== 32'h42) begin errors++; $display("FAIL hold_A1 got %h want 42", do_A1); end
    checks++; if (do_A0 !== 32'h42) begin errors++; $display("FAIL hold_A0 got %h want 42", do_A0); end
    checks++; if (do_Imm1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_imm got %h want ffffffff", do_Imm1); end
    checks++; if (do_rd1 !== 5'd6) begin errors++; $display("FAIL hold_rd got %0d want 6", do_rd1); end
    checks++; if (do_PC1 !== 32'h200) begin errors++; $display("FAIL hold_pc got %h want 200", do_PC1); end
  endtask

  task automatic test_flush();
    di_valid = 1'b1; di_IR = 32'h3C068000; di_PC = 32'h300; flush = 1'b1;
    #1;
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", di_ready1); end
    tick();
    flush = 1'b0; di_valid = 1'b0; do_ready = 1'b1;
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL flush_valid1 got %b want 0", do_valid1); end
    checks++; if (do_valid0 !== 1'b0) begin errors++; $display("FAIL flush_valid0 got %b want 0", do_valid0); end
  endtask

  task automatic test_r0();
    wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hFFFFFFFF;
    di_valid = 1'b1; di_IR = 32'h00003821; di_PC = 32'h400;
    tick();
    wb_we = 1'b0;
    checks++; if (do_A1 !== 32'h0) begin errors++; $display("FAIL r0_byp_A got %h want 0", do_A1); end
    checks++; if (do_B1 !== 32'h0) begin errors++; $display("FAIL r0_byp_B got %h want 0", do_B1); end
    tick();
    di_valid = 1'b0;
    checks++; if (do_A1 !== 32'h0) begin errors++; $display("FAIL r0_read_A got %h want 0", do_A1); end
    checks++; if (do_B0 !== 32'h0) begin errors++; $display("FAIL r0_read_B0 got %h want 0", do_B0); end
  endtask

  task automatic test_reset_mid_stall();
    ex_load = 1'b1; ex_rt = 5'd5; di_valid = 1'b1; di_IR = 32'h24A6FFFF; di_PC = 32'h500;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (di_ready1 !== 1'b0) begin errors++; $display("FAIL rst_stall_ready got %b want 0", di_ready1); end
    tick();
    checks++; if (do_valid1 !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got %b want 0", do_valid1); end
    checks++; if (do_IR1 !== 32'h0) begin errors++; $display("FAIL rst_stall_ir got %h want 0", do_IR1); end
    rst_n = 1'b1; ex_load = 1'b0;
    #1;
    checks++; if (di_ready1 !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", di_ready1); end
    tick();
    di_valid = 1'b0;
    checks++; if (do_valid1 !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", do_valid1); end
    checks++; if (do_A1 !== 32'h42) begin errors++; $display("FAIL post_rst_A got %h want 42", do_A1); end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_back_to_back();
    test_bypass();
    test_hazard();
    test_hold_refresh();
    test_flush();
    test_r0();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
